// File: rtl/score_bank.sv
// Multi-channel score keeper: combo-multiplied hits, penalties, saturation, high-score tracking, serial BCD readout.
// Latency: scores 1 cycle after an event; high score 1 cycle after o_score; BCD result SCORE_W+1 cycles after request.
// Backpressure: none on score events; BCD requests arriving while the converter is busy are dropped, not queued.
module score_bank #(
    parameter int N_CH      = 2,
    parameter int SCORE_W   = 10,
    parameter int PTS_W     = 4,
    parameter int COMBO_WIN = 16,
    parameter int COMBO_MAX = 4,
    parameter int BCD_DIG   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_clear,
    input  logic [N_CH-1:0]               i_hit,
    input  logic [N_CH-1:0]               i_penalty,
    input  logic [N_CH*PTS_W-1:0]         i_pts,
    output logic [N_CH*SCORE_W-1:0]       o_score,
    output logic [N_CH-1:0]               o_sat,
    output logic [SCORE_W-1:0]            o_high_score,
    output logic [$clog2(N_CH+1)-1:0]     o_high_ch,
    input  logic                          i_bcd_req,
    input  logic [$clog2(N_CH+1)-1:0]     i_bcd_sel,
    output logic                          o_bcd_busy,
    output logic                          o_bcd_valid,
    output logic [BCD_DIG*4-1:0]          o_bcd
);

    localparam int SEL_W  = $clog2(N_CH+1);
    localparam int MULT_W = 3;
    localparam int TMR_W  = $clog2(COMBO_WIN+1);
    localparam int SUM_W  = SCORE_W + PTS_W + 3;
    localparam int BCD_W  = BCD_DIG * 4;
    localparam int CNT_W  = $clog2(SCORE_W+1);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [MULT_W-1:0]  MULT_ONE  = MULT_W'(1);
    localparam logic [MULT_W-1:0]  MULT_CAP  = MULT_W'(COMBO_MAX);
    // A fresh combo's second hit runs at x2 unless the cap is lower.
    localparam logic [MULT_W-1:0]  MULT_TWO  = (COMBO_MAX >= 2) ? MULT_W'(2) : MULT_W'(COMBO_MAX);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(COMBO_WIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } bcd_st_t;

    // Per-channel state
    logic [SCORE_W-1:0] score_q [N_CH];
    logic [SCORE_W-1:0] score_d [N_CH];
    logic [MULT_W-1:0]  mult_q  [N_CH];
    logic [MULT_W-1:0]  mult_d  [N_CH];
    logic [TMR_W-1:0]   tmr_q   [N_CH];
    logic [TMR_W-1:0]   tmr_d   [N_CH];
    logic [N_CH-1:0]    sat_q, sat_d;
    logic [SUM_W-1:0]   sum_ch  [N_CH];
    logic [SUM_W-1:0]   pts_ext [N_CH];

    // High-score tracking
    logic [SCORE_W-1:0] high_q, high_d;
    logic [SEL_W-1:0]   high_ch_q, high_ch_d;
    logic [SCORE_W-1:0] best_val;
    logic [SEL_W-1:0]   best_ch;

    // BCD converter
    bcd_st_t            state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   obcd_q, obcd_d;
    logic [SCORE_W-1:0] sel_val;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;

    // Widened point value and hit sum per channel; wide enough that pts*mult never wraps
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            pts_ext[k] = SUM_W'(i_pts[k*PTS_W +: PTS_W]);
            sum_ch[k]  = SUM_W'(score_q[k]) + pts_ext[k] * SUM_W'(mult_q[k]);
        end
    end

    // Per-channel next state: clear > penalty > hit > combo timer decay
    always_comb begin
        sat_d = sat_q;
        for (int k = 0; k < N_CH; k++) begin
            score_d[k] = score_q[k];
            mult_d[k]  = mult_q[k];
            tmr_d[k]   = tmr_q[k];
            if (i_clear) begin
                score_d[k] = '0;
                mult_d[k]  = MULT_ONE;
                tmr_d[k]   = '0;
                sat_d[k]   = 1'b0;
            end else if (i_penalty[k]) begin
                if (pts_ext[k] >= SUM_W'(score_q[k])) begin
                    score_d[k] = '0;
                end else begin
                    score_d[k] = score_q[k] - SCORE_W'(pts_ext[k]);
                end
                mult_d[k] = MULT_ONE;
                tmr_d[k]  = '0;
            end else if (i_hit[k]) begin
                if (sum_ch[k] > SUM_W'(SCORE_MAX)) begin
                    score_d[k] = SCORE_MAX;
                    sat_d[k]   = 1'b1;
                end else begin
                    score_d[k] = sum_ch[k][SCORE_W-1:0];
                end
                if (tmr_q[k] != '0) begin
                    mult_d[k] = (mult_q[k] >= MULT_CAP) ? MULT_CAP : mult_q[k] + MULT_ONE;
                end else begin
                    mult_d[k] = MULT_TWO;
                end
                tmr_d[k] = TMR_LOAD;
            end else if (tmr_q[k] != '0) begin
                tmr_d[k] = tmr_q[k] - TMR_W'(1);
                if (tmr_q[k] == TMR_W'(1)) begin
                    mult_d[k] = MULT_ONE;
                end
            end
        end
    end

    // Highest current score (strict compare keeps the lowest index on ties), latched only when it beats the record
    always_comb begin
        best_val  = score_q[0];
        best_ch   = '0;
        for (int k = 1; k < N_CH; k++) begin
            if (score_q[k] > best_val) begin
                best_val = score_q[k];
                best_ch  = SEL_W'(k);
            end
        end
        high_d    = high_q;
        high_ch_d = high_ch_q;
        if (best_val > high_q) begin
            high_d    = best_val;
            high_ch_d = best_ch;
        end
    end

    // Double-dabble converter: snapshot in IDLE, one add-3/shift per SHIFT cycle, publish on entry to DONE
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        obcd_d  = obcd_q;
        sel_val = high_q;
        for (int k = 0; k < N_CH; k++) begin
            if (i_bcd_sel == SEL_W'(k)) begin
                sel_val = score_q[k];
            end
        end
        bcd_adj = bcd_q;
        for (int d = 0; d < BCD_DIG; d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        case (state_q)
            ST_IDLE: begin
                if (i_bcd_req) begin
                    bin_d   = sel_val;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(SCORE_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    obcd_d  = bcd_shift;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                score_q[k] <= '0;
                mult_q[k]  <= MULT_ONE;
                tmr_q[k]   <= '0;
            end
            sat_q     <= '0;
            high_q    <= '0;
            high_ch_q <= '0;
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            obcd_q    <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                score_q[k] <= score_d[k];
                mult_q[k]  <= mult_d[k];
                tmr_q[k]   <= tmr_d[k];
            end
            sat_q     <= sat_d;
            high_q    <= high_d;
            high_ch_q <= high_ch_d;
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            obcd_q    <= obcd_d;
        end
    end

    // Flatten per-channel scores onto the output bus
    always_comb begin
        o_score = '0;
        for (int k = 0; k < N_CH; k++) begin
            o_score[k*SCORE_W +: SCORE_W] = score_q[k];
        end
    end

    assign o_sat        = sat_q;
    assign o_high_score = high_q;
    assign o_high_ch    = high_ch_q;
    assign o_bcd_busy   = (state_q != ST_IDLE);
    assign o_bcd_valid  = (state_q == ST_DONE);
    assign o_bcd        = obcd_q;

endmodule

// File: tb/tb_score_bank.sv
// Directed bench for score_bank: vector table for combo/penalty/clear sequences,
// hand-written sequences for saturation, high-score ties and BCD conversion timing.
module tb_score_bank;

    localparam int N_CH      = 2;
    localparam int SCORE_W   = 10;
    localparam int PTS_W     = 4;
    localparam int COMBO_WIN = 16;
    localparam int COMBO_MAX = 4;
    localparam int BCD_DIG   = 4;
    localparam int SEL_W     = 2;
    localparam int NVEC      = 18;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     i_clear;
    logic [N_CH-1:0]          i_hit;
    logic [N_CH-1:0]          i_penalty;
    logic [N_CH*PTS_W-1:0]    i_pts;
    logic [N_CH*SCORE_W-1:0]  o_score;
    logic [N_CH-1:0]          o_sat;
    logic [SCORE_W-1:0]       o_high_score;
    logic [SEL_W-1:0]         o_high_ch;
    logic                     i_bcd_req;
    logic [SEL_W-1:0]         i_bcd_sel;
    logic                     o_bcd_busy;
    logic                     o_bcd_valid;
    logic [BCD_DIG*4-1:0]     o_bcd;

    logic [SCORE_W-1:0] s0, s1;
    assign s0 = o_score[0 +: SCORE_W];
    assign s1 = o_score[SCORE_W +: SCORE_W];

    always #5 clk = ~clk;

    score_bank #(
        .N_CH(N_CH), .SCORE_W(SCORE_W), .PTS_W(PTS_W),
        .COMBO_WIN(COMBO_WIN), .COMBO_MAX(COMBO_MAX), .BCD_DIG(BCD_DIG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_hit(i_hit),
        .i_penalty(i_penalty), .i_pts(i_pts), .o_score(o_score), .o_sat(o_sat),
        .o_high_score(o_high_score), .o_high_ch(o_high_ch), .i_bcd_req(i_bcd_req),
        .i_bcd_sel(i_bcd_sel), .o_bcd_busy(o_bcd_busy), .o_bcd_valid(o_bcd_valid),
        .o_bcd(o_bcd)
    );

    typedef struct {
        logic [1:0] hit;
        logic [1:0] pen;
        logic       clr;
        logic [3:0] p0;
        logic [3:0] p1;
        int         idle_after;
        logic [9:0] e0;
        logic [9:0] e1;
    } vec_t;

    vec_t tbl [NVEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_clear   = 1'b0;
        i_hit     = '0;
        i_penalty = '0;
        i_bcd_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_pts     = '0;
        i_bcd_sel = '0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    // One hit per masked channel, then enough idle cycles for the combo to lapse (next hit scores x1)
    task automatic hit_x1(input logic [1:0] mask, input logic [3:0] p0, input logic [3:0] p1);
        i_hit = mask;
        i_pts = {p1, p0};
        tick();
        i_hit = '0;
        repeat (COMBO_WIN) tick();
    endtask

    // Waits up to 20 cycles for the valid pulse; lat = edges after the request edge, -1 if none
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (o_bcd_valid && lat < 0) lat = c;
        end
    endtask

    task automatic bcd_conv(input logic [1:0] sel, input logic [15:0] exp, input string name);
        int lat;
        i_bcd_sel = sel;
        i_bcd_req = 1'b1;
        tick();
        i_bcd_req = 1'b0;
        wait_valid(lat);
        chk({name, "_lat"}, 32'(lat + 1), 32'(SCORE_W + 1));
        chk({name, "_bcd"}, 32'(o_bcd), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        logic [3:0] p1v;

        //             hit    pen    clr   p0    p1   idle  e0      e1
        tbl[0]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd3,  10'd0};
        tbl[1]  = '{2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd3,  10'd0};
        tbl[2]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd9,  10'd0};
        tbl[3]  = '{2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd9,  10'd0};
        tbl[4]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd18, 10'd0};
        tbl[5]  = '{2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd18, 10'd0};
        tbl[6]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd30, 10'd0};
        tbl[7]  = '{2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd30, 10'd0};
        tbl[8]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 16, 10'd42, 10'd0};
        tbl[9]  = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 15, 10'd45, 10'd0};
        tbl[10] = '{2'b01, 2'b00, 1'b0, 4'd3, 4'd0, 0,  10'd51, 10'd0};
        tbl[11] = '{2'b10, 2'b00, 1'b0, 4'd0, 4'd4, 0,  10'd51, 10'd4};
        tbl[12] = '{2'b00, 2'b10, 1'b0, 4'd0, 4'd9, 0,  10'd51, 10'd0};
        tbl[13] = '{2'b10, 2'b00, 1'b0, 4'd0, 4'd6, 0,  10'd51, 10'd6};
        tbl[14] = '{2'b10, 2'b10, 1'b0, 4'd0, 4'd2, 0,  10'd51, 10'd4};
        tbl[15] = '{2'b10, 2'b00, 1'b0, 4'd0, 4'd1, 0,  10'd51, 10'd5};
        tbl[16] = '{2'b11, 2'b00, 1'b1, 4'd7, 4'd7, 0,  10'd0,  10'd0};
        tbl[17] = '{2'b01, 2'b00, 1'b0, 4'd1, 4'd0, 0,  10'd1,  10'd0};

        // Reset values and single-hit latency
        do_reset();
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_sat", 32'(o_sat), 32'd0);
        chk("rst_high", 32'(o_high_score), 32'd0);
        chk("rst_high_ch", 32'(o_high_ch), 32'd0);
        chk("rst_busy", 32'(o_bcd_busy), 32'd0);
        chk("rst_valid", 32'(o_bcd_valid), 32'd0);
        chk("rst_bcd", 32'(o_bcd), 32'd0);
        i_hit = 2'b01;
        i_pts = {4'd0, 4'd5};
        tick();
        idle_inputs();
        chk("hit1_score", 32'(s0), 32'd5);
        chk("hit1_high_lag", 32'(o_high_score), 32'd0);
        tick();
        chk("hit1_high", 32'(o_high_score), 32'd5);
        chk("hit1_high_ch", 32'(o_high_ch), 32'd0);

        // Combo, window boundary, penalty, hit+penalty, clear
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            i_hit     = tbl[i].hit;
            i_penalty = tbl[i].pen;
            i_clear   = tbl[i].clr;
            i_pts     = {tbl[i].p1, tbl[i].p0};
            tick();
            idle_inputs();
            chk($sformatf("vec%0d_ch0", i), 32'(s0), 32'(tbl[i].e0));
            chk($sformatf("vec%0d_ch1", i), 32'(s1), 32'(tbl[i].e1));
            repeat (tbl[i].idle_after) tick();
        end
        chk("tbl_high_kept", 32'(o_high_score), 32'd51);
        chk("tbl_high_ch", 32'(o_high_ch), 32'd0);

        // Saturation: ch0 to 1020 then +15 overflows; ch1 to 1008 then +15 lands exactly on max
        do_reset();
        for (int i = 0; i < 68; i++) begin
            p1v = (i < 67) ? 4'd15 : 4'd3;
            hit_x1(2'b11, 4'd15, p1v);
        end
        chk("sat_pre_ch0", 32'(s0), 32'd1020);
        chk("sat_pre_ch1", 32'(s1), 32'd1008);
        chk("sat_pre_flag", 32'(o_sat), 32'd0);
        i_hit = 2'b11;
        i_pts = {4'd15, 4'd15};
        tick();
        chk("sat_ch0", 32'(s0), 32'd1023);
        chk("sat_ch1_exact", 32'(s1), 32'd1023);
        chk("sat_flag_ch0_only", 32'(o_sat), 32'd1);
        tick();
        idle_inputs();
        chk("sat_hold_ch0", 32'(s0), 32'd1023);
        chk("sat_hold_ch1", 32'(s1), 32'd1023);
        chk("sat_flag_both", 32'(o_sat), 32'd3);

        // BCD: latency, ignored request while busy, hold afterwards
        i_bcd_sel = 2'd0;
        i_bcd_req = 1'b1;
        tick();
        chk("bcd_busy_start", 32'(o_bcd_busy), 32'd1);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                i_bcd_req = 1'b1;
                i_bcd_sel = 2'd2;
            end else begin
                i_bcd_req = 1'b0;
            end
            tick();
            if (o_bcd_valid && lat < 0) lat = c;
            if (lat > 0) break;
        end
        i_bcd_req = 1'b0;
        chk("bcd_lat", 32'(lat + 1), 32'(SCORE_W + 1));
        chk("bcd_1023", 32'(o_bcd), 32'h1023);
        chk("bcd_busy_done", 32'(o_bcd_busy), 32'd1);
        tick();
        chk("bcd_valid_pulse", 32'(o_bcd_valid), 32'd0);
        chk("bcd_idle", 32'(o_bcd_busy), 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (o_bcd_valid) pulses++;
        end
        chk("bcd_no_queue", 32'(pulses), 32'd0);
        chk("bcd_hold", 32'(o_bcd), 32'h1023);

        // Clear keeps the high score; source select covers channel and high score
        i_clear = 1'b1;
        i_hit   = 2'b11;
        tick();
        idle_inputs();
        chk("clr_scores", 32'(o_score), 32'd0);
        chk("clr_sat", 32'(o_sat), 32'd0);
        tick();
        chk("clr_high_kept", 32'(o_high_score), 32'd1023);
        bcd_conv(2'd1, 16'h0000, "bcd_ch1");
        bcd_conv(2'd2, 16'h1023, "bcd_high");

        // Reset aborts a conversion in flight
        i_bcd_sel = 2'd2;
        i_bcd_req = 1'b1;
        tick();
        i_bcd_req = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", 32'(o_bcd_busy), 32'd0);
        chk("abort_bcd", 32'(o_bcd), 32'd0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (o_bcd_valid) pulses++;
            tick();
        end
        chk("abort_no_valid", 32'(pulses), 32'd0);

        // High-score tie goes to ch0, a later strict increase moves it to ch1
        do_reset();
        for (int i = 0; i < 46; i++) hit_x1(2'b11, 4'd15, 4'd15);
        hit_x1(2'b11, 4'd10, 4'd10);
        chk("tie_ch0", 32'(s0), 32'd700);
        chk("tie_ch1", 32'(s1), 32'd700);
        chk("tie_high", 32'(o_high_score), 32'd700);
        chk("tie_high_ch", 32'(o_high_ch), 32'd0);
        hit_x1(2'b10, 4'd0, 4'd1);
        chk("lead_ch1", 32'(s1), 32'd701);
        chk("lead_high", 32'(o_high_score), 32'd701);
        chk("lead_high_ch", 32'(o_high_ch), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
